// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: issues start/read strobes to an external ADC, assembles
// the 8-bit result from two nibble reads and emits 2^AVG_LOG2-sample averages.
module adc_conv_sequencer #(
    parameter int unsigned WR_CYCLES  = 4,
    parameter int unsigned RD_CYCLES  = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       adc_int,
    input  logic [3:0] adc_data,
    output logic       adc_wr_n,
    output logic       adc_rd_n,
    output logic       nib_sel,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       timeout_err,
    output logic       busy
);

    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

    localparam logic [7:0]       WR_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [7:0]       RD_LAST  = 8'(RD_CYCLES - 1);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WAIT,
        S_RD_HI,
        S_RD_LO,
        S_ACC,
        S_GAP
    } state_t;

    state_t           state;
    logic [7:0]       cyc;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       hi;
    logic [3:0]       lo;
    logic             int_m;
    logic             int_s;

    // adc_int is asynchronous to clk; idle level of the synchronizer is 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_m <= 1'b1;
            int_s <= 1'b1;
        end else begin
            int_m <= adc_int;
            int_s <= int_m;
        end
    end

    // Accumulator is AVG_LOG2 bits wider than a sample, so the sum never wraps
    assign acc_sum = acc + ACC_W'({hi, lo});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cyc          <= '0;
            acc          <= '0;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            adc_wr_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            nib_sel      <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cyc <= '0;
                    if (enable) begin
                        state    <= S_WR;
                        adc_wr_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_WR: begin
                    if (cyc == WR_LAST) begin
                        state    <= S_WAIT;
                        adc_wr_n <= 1'b1;
                        cyc      <= '0;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!int_s) begin
                        state    <= S_RD_HI;
                        adc_rd_n <= 1'b0;
                        nib_sel  <= 1'b1;
                        cyc      <= '0;
                    end else if (cyc == TO_LAST) begin
                        // Hung converter: keep the partial average and retry after GAP
                        timeout_err <= 1'b1;
                        state       <= S_GAP;
                        cyc         <= '0;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                S_RD_HI: begin
                    if (cyc == RD_LAST) begin
                        hi      <= adc_data;
                        nib_sel <= 1'b0;
                        state   <= S_RD_LO;
                        cyc     <= '0;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                S_RD_LO: begin
                    if (cyc == RD_LAST) begin
                        lo       <= adc_data;
                        adc_rd_n <= 1'b1;
                        nib_sel  <= 1'b1;
                        state    <= S_ACC;
                        cyc      <= '0;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                S_ACC: begin
                    state <= S_GAP;
                    cyc   <= '0;
                    if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        acc          <= '0;
                        sample       <= 8'(acc_sum >> AVG_LOG2);
                        sample_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        acc <= acc_sum;
                    end
                end
                S_GAP: begin
                    if (cyc == GAP_LAST) begin
                        cyc <= '0;
                        if (enable) begin
                            state    <= S_WR;
                            adc_wr_n <= 1'b0;
                        end else begin
                            // A partial average does not survive a return to IDLE
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            acc   <= '0;
                            cnt   <= '0;
                        end
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    adc_wr_n <= 1'b1;
                    adc_rd_n <= 1'b1;
                    nib_sel  <= 1'b1;
                    busy     <= 1'b0;
                    cyc      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: two instances (AVG_LOG2=0 and 2) share one ADC model;
// an averaging reference model and scoreboard check every sample_valid pulse.
module tb_adc_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       adc_int;
    logic [3:0] adc_data;
    logic       wr0, rd0, nib0, v0, to0, busy0;
    logic       wr2, rd2, nib2, v2, to2, busy2;
    logic [7:0] s0, s2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int int_fall_cyc = 0;
    int n_valid0 = 0;
    int n_valid2 = 0;

    logic [7:0] conv_q[$];
    logic [7:0] part2[$];
    logic [7:0] exp0[$];
    logic [7:0] exp2[$];
    logic [7:0] conv_val = 8'h00;
    logic [7:0] adc_v;
    int         adc_dly, adc_n;
    bit         adc_hang = 1'b0;
    int         fixed_dly = 0;

    typedef struct packed {
        logic [31:0] vals;
        logic [7:0]  avg;
    } vec_t;
    vec_t tbl[4];

    adc_conv_sequencer #(.AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .adc_int(adc_int), .adc_data(adc_data),
        .adc_wr_n(wr0), .adc_rd_n(rd0), .nib_sel(nib0), .sample(s0),
        .sample_valid(v0), .timeout_err(to0), .busy(busy0)
    );

    adc_conv_sequencer #(.AVG_LOG2(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .adc_int(adc_int), .adc_data(adc_data),
        .adc_wr_n(wr2), .adc_rd_n(rd2), .nib_sel(nib2), .sample(s2),
        .sample_valid(v2), .timeout_err(to2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign adc_data = nib2 ? conv_val[7:4] : conv_val[3:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every delivered conversion is a sample at AVG_LOG2=0;
    // at AVG_LOG2=2 each group of four is averaged with truncation.
    function automatic void model_push(input logic [7:0] v);
        int sum;
        exp0.push_back(v);
        part2.push_back(v);
        if (part2.size() == 4) begin
            sum = 0;
            foreach (part2[i]) sum += int'(part2[i]);
            exp2.push_back(8'(sum / 4));
            part2.delete();
        end
    endfunction

    function automatic void model_discard();
        part2.delete();
    endfunction

    function automatic void model_reset();
        part2.delete();
        exp0.delete();
        exp2.delete();
        conv_q.delete();
    endfunction

    // ADC model: answers each conversion start by pulling adc_int low, releases it on read
    initial begin : adc_model
        adc_int = 1'b1;
        forever begin
            @(negedge clk);
            if (wr2 === 1'b0) begin
                while (wr2 === 1'b0) @(negedge clk);
                if (!adc_hang && rst !== 1'b1) begin
                    adc_v   = (conv_q.size() > 0) ? conv_q.pop_front() : 8'($urandom);
                    adc_dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(20, 1));
                    repeat (adc_dly) @(posedge clk);
                    #1;
                    conv_val     = adc_v;
                    adc_int      = 1'b0;
                    int_fall_cyc = cyc_cnt;
                    model_push(adc_v);
                    adc_n = 0;
                    while (rd2 !== 1'b0 && adc_n < 50) begin
                        @(negedge clk);
                        adc_n++;
                    end
                    check("adc_read_started", rd2, 0);
                    adc_int = 1'b1;
                end
            end
        end
    end

    // Scoreboard: every sample_valid pulse must match the next modelled sample
    initial begin : scoreboard
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (v0 === 1'b1) begin
                    n_valid0++;
                    if (exp0.size() == 0) check("s0_unexpected_valid", v0, 0);
                    else begin
                        e = exp0.pop_front();
                        check("s0_sample", s0, e);
                    end
                end
                if (v2 === 1'b1) begin
                    n_valid2++;
                    if (exp2.size() == 0) check("s2_unexpected_valid", v2, 0);
                    else begin
                        e = exp2.pop_front();
                        check("s2_sample", s2, e);
                    end
                end
            end
        end
    end

    task automatic wait_valid0(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (v0 !== 1'b1 && n < budget);
        check("wait_valid0", v0, 1);
    endtask

    task automatic wait_valid2(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (v2 !== 1'b1 && n < budget);
        check("wait_valid2", v2, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy0 !== 1'b0 || busy2 !== 1'b0) && n < budget);
        check("idle_busy0", busy0, 0);
        check("idle_busy2", busy2, 0);
        check("idle_wr_n", wr2, 1);
    endtask

    task automatic push_group(input logic [31:0] vals);
        for (int i = 3; i >= 0; i--) conv_q.push_back(vals[i*8 +: 8]);
    endtask

    task automatic finish_group(input logic [7:0] avg, input string name, input int nv);
        wait_valid2(3000);
        check({name, "_avg"}, s2, avg);
        enable = 1'b0;
        wait_idle(300);
        check({name, "_nvalid"}, n_valid2 - nv, 1);
        model_discard();
    endtask

    task automatic run_group(input logic [31:0] vals, input logic [7:0] avg, input string name);
        int nv;
        push_group(vals);
        nv = n_valid2;
        enable = 1'b1;
        finish_group(avg, name, nv);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n, k, w0, w2, r0, r2, nv0, nv2;
        logic [3:0] pat0, pat2;

        tbl[0] = '{vals: 32'h40424446, avg: 8'h43};
        tbl[1] = '{vals: 32'hFFFFFFFF, avg: 8'hFF};
        tbl[2] = '{vals: 32'h01020303, avg: 8'h02};
        tbl[3] = '{vals: 32'h10203040, avg: 8'h28};

        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_n", wr2, 1);
        check("rst_rd_n", rd2, 1);
        check("rst_nib_sel", nib2, 1);
        check("rst_sample", s2, 0);
        check("rst_valid", v2, 0);
        check("rst_timeout", to2, 0);
        check("rst_busy", busy2, 0);
        check("rst_busy0", busy0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_group(tbl[i].vals, tbl[i].avg, $sformatf("tbl%0d", i));

        // Single conversion: strobe widths, nibble order and latency
        fixed_dly = 10;
        conv_q.push_back(8'hA5);
        conv_q.push_back(8'h77);
        nv0 = n_valid0;
        nv2 = n_valid2;
        enable = 1'b1;
        n = 0;
        while (wr2 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        w0 = 0; w2 = 0;
        while ((wr0 === 1'b0 || wr2 === 1'b0) && n < 100) begin
            if (wr0 === 1'b0) w0++;
            if (wr2 === 1'b0) w2++;
            @(negedge clk); n++;
        end
        check("t1_wr0_low_clocks", w0, 4);
        check("t1_wr2_low_clocks", w2, 4);
        n = 0;
        while (rd2 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        r0 = 0; r2 = 0; pat0 = '0; pat2 = '0;
        while ((rd0 === 1'b0 || rd2 === 1'b0) && n < 150) begin
            if (rd0 === 1'b0) begin r0++; pat0 = {pat0[2:0], nib0}; end
            if (rd2 === 1'b0) begin r2++; pat2 = {pat2[2:0], nib2}; end
            @(negedge clk); n++;
        end
        check("t1_rd0_low_clocks", r0, 4);
        check("t1_rd2_low_clocks", r2, 4);
        check("t1_nib0_pattern", pat0, 4'b1100);
        check("t1_nib2_pattern", pat2, 4'b1100);
        wait_valid0(100);
        check("t1_latency", cyc_cnt - int_fall_cyc, 8);
        check("t1_sample", s0, 8'hA5);
        @(negedge clk);
        check("t1_valid_one_clock", v0, 0);
        fixed_dly = 0;

        // enable dropped in RD_HI: conversion still accumulates, partial average discarded
        n = 0;
        while (!(rd2 === 1'b0 && nib2 === 1'b1) && n < 200) begin @(negedge clk); n++; end
        check("t5_in_rd_hi", rd2, 0);
        enable = 1'b0;
        wait_idle(300);
        check("t5_acc_ran", n_valid0 - nv0, 2);
        check("t5_no_avg_valid", n_valid2 - nv2, 0);
        model_discard();
        run_group(32'h0808080C, 8'h09, "t5_fresh");

        // Hung converter: timeout after 255 WAIT clocks, GAP, then retry
        adc_hang = 1'b1;
        push_group(32'h00FF00FF);
        check("t4_timeout_pre", to2, 0);
        nv2 = n_valid2;
        enable = 1'b1;
        n = 0;
        while (wr2 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        while (wr2 === 1'b0 && n < 100) begin @(negedge clk); n++; end
        k = 0;
        while (to2 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check("t4_wait_clocks", k, 255);
        check("t4_timeout0", to0, 1);
        adc_hang = 1'b0;
        k = 0;
        while (wr2 !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("t4_gap_clocks", k, 16);
        finish_group(8'h7F, "t4_after_timeout", nv2);
        check("t4_timeout_sticky", to2, 1);

        // Reset during RD_LO takes effect immediately
        conv_q.push_back(8'h5A);
        enable = 1'b1;
        n = 0;
        while (!(rd2 === 1'b0 && nib2 === 1'b0) && n < 300) begin @(negedge clk); n++; end
        check("t6_in_rd_lo", nib2, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_rd_n", rd2, 1);
        check("t6_sample2", s2, 8'h00);
        check("t6_sample0", s0, 8'h00);
        check("t6_timeout", to2, 0);
        check("t6_busy", busy2, 0);
        check("t6_nib_sel", nib2, 1);
        model_reset();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nv0 = n_valid0;
        push_group(32'h12345678);
        enable = 1'b1;
        wait_valid0(300);
        check("t6_first_sample", s0, 8'h12);
        finish_group(8'h45, "t6_restart", n_valid2);

        // Randomized data and response delays against the reference model
        enable = 1'b1;
        for (int i = 0; i < 40; i++) wait_valid0(300);
        enable = 1'b0;
        wait_idle(300);
        model_discard();

        check("end_exp0_drained", exp0.size(), 0);
        check("end_exp2_drained", exp2.size(), 0);
        check("end_no_timeout", to2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
Sequences conversions of the oven's external ADC and feeds averaged temperature samples to the oven control FSM.
- Generates the ADC start/read strobes and waits for the ADC's interrupt.
- Assembles the 8-bit result from two 4-bit reads over the nibble bus.
- Averages 2^AVG_LOG2 conversions and flags a hung converter with a timeout.
- Sits between the ADC pins and the temperature consumers (display, oven FSM), replacing the free-running enable strobe.

Parameters:
WR_CYCLES, 4, clocks adc_wr_n is held low per conversion start (1..15)
RD_CYCLES, 2, clocks each nibble read is held before latching (1..15)
TIMEOUT, 255, max clocks spent in WAIT before abort (1..255)
GAP_CYCLES, 16, idle clocks between conversions (1..255)
AVG_LOG2, 2, log2 of samples averaged per output (0..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; 1 = run continuous conversions
adc_int  in  1  ADC end-of-conversion, active-low, asynchronous to clk
adc_data  in  4  ADC nibble bus
adc_wr_n  out  1  conversion start strobe, active-low
adc_rd_n  out  1  read strobe, active-low
nib_sel  out  1  1 = ADC drives high nibble, 0 = low nibble
sample  out  8  averaged temperature sample
sample_valid  out  1  one-clock pulse when sample updates
timeout_err  out  1  sticky, set on any WAIT timeout
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values:
  - adc_wr_n=1, adc_rd_n=1, nib_sel=1, sample=8'h00, sample_valid=0, timeout_err=0, busy=0.
  - State IDLE; accumulator, sample counter, cycle counter and sync flops are cleared (sync flops to 1).
  - Reset asserted mid-operation forces these values immediately, with no completion of the transfer in flight.
- adc_int passes through a 2-flop synchronizer; all decisions use the synchronized value int_s.
- State machine, registered, all outputs driven from registers:
  - IDLE: strobes inactive. When enable=1, go to WR on the next clock.
  - WR: adc_wr_n=0 for exactly WR_CYCLES clocks, then WAIT.
  - WAIT: strobes high; cycle counter runs.
    - int_s=0 goes to RD_HI.
    - If the counter reaches TIMEOUT with int_s still 1: set timeout_err, go to GAP. Accumulator and sample count are kept; the conversion is simply retried.
  - RD_HI: adc_rd_n=0, nib_sel=1 for RD_CYCLES clocks; adc_data is latched into hi[3:0] on the last clock. Then RD_LO.
  - RD_LO: adc_rd_n=0, nib_sel=0 for RD_CYCLES clocks; adc_data is latched into lo[3:0] on the last clock. adc_rd_n stays low with no glitch across the RD_HI to RD_LO change. Then ACC.
  - ACC, 1 clock, strobes high:
    - acc += {hi,lo}; acc is 8+AVG_LOG2 bits wide, so there is no overflow.
    - cnt += 1.
    - If cnt wraps to 0 (2^AVG_LOG2 samples collected): on the same edge, sample <= acc_next >> AVG_LOG2 (truncating), sample_valid=1 for that clock only, and acc cleared.
    - Then GAP.
  - GAP: strobes high for GAP_CYCLES clocks. Then WR if enable=1, else IDLE.
- enable dropping mid-conversion:
  - The current conversion completes through ACC; it is not aborted.
  - Exit to IDLE happens at the end of GAP.
  - Entering IDLE clears acc and cnt, so a partial average is discarded.
- Latency, AVG_LOG2=0: adc_int falls at edge N → sample_valid high in cycle N+2+1+2*RD_CYCLES+1 (2 sync, 1 WAIT exit, reads, ACC); concretely N+8 at defaults.
- timeout_err clears only on rst.
- busy = (state != IDLE).

Test Plan:
1. AVG_LOG2=0, enable=1; model drops adc_int 10 clocks after adc_wr_n rises; nibbles 4'hA then 4'h5 → adc_wr_n low exactly 4 clocks; rd_n low 4 clocks with nib_sel 1,1,0,0; sample=8'hA5 with a one-clock sample_valid 8 clocks after adc_int falls.
2. AVG_LOG2=2; four conversions returning 8'h40, 8'h42, 8'h44, 8'h46 → exactly one sample_valid, sample=8'h43; no valid after the first three.
3. Saturation: AVG_LOG2=2, four conversions of 8'hFF → sample=8'hFF, no wrap.
4. adc_int held high → timeout_err rises after 255 WAIT clocks, FSM enters GAP then re-issues adc_wr_n. A later good conversion still produces samples; timeout_err stays 1 until rst.
5. enable dropped during RD_HI → read completes, ACC runs, GAP runs, then IDLE with busy=0. With AVG_LOG2=2 and cnt=1, no sample_valid and acc cleared; the next enable starts a fresh average.
6. rst pulsed during RD_LO → adc_rd_n=1, sample=8'h00, timeout_err=0, busy=0 asynchronously; restart after rst gives the correct first sample.
